pwm_ramp_controller: RTL

PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

---
 rtl/pwm_pkg.sv | 8 +
 rtl/pwm_period_tick.sv | 24 ++
 rtl/pwm_ramp_controller.sv | 93 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type and sign-magnitude helpers for the PWM ramp controller.
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, ZERO_HOLD} pwm_state_e;
  // A zero magnitude always carries a positive sign, so -0 collapses to +0.
  function automatic logic norm_sign(input logic sign, input logic mag_nz);
    return sign & mag_nz;
  endfunction
endpackage

// File: rtl/pwm_period_tick.sv
// pwm_period_tick: free-running one-cycle pulse every N clocks, first pulse N clocks after reset.
module pwm_period_tick #(
  parameter int N = 10
) (
  input  logic Clock,
  input  logic Reset_n,
  output logic Tick
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, wrap;
  assign wrap = cnt_q == CW'(N - 1);
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap;
    end
  end
  assign Tick = tick_q;
endmodule

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: slews a sign-magnitude PWM duty word toward a commanded target,
// one bounded step per PWM period, passing through a zero-duty dwell on sign reversal.
module pwm_ramp_controller
  import pwm_pkg::*;
#(
  parameter int ClockPeriod_ns   = 20,
  parameter int PWMPeriod_ns     = 200_000,
  parameter int Size             = 4,
  parameter int Step             = 1,
  parameter int ZeroHoldPeriods  = 1
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic [Size-1:0] CmdData,
  input  logic            CmdValid,
  output logic            CmdReady,
  input  logic            Stop,
  output logic [Size-1:0] Data,
  output logic            Tick,
  output logic            Busy,
  output logic            AtTarget
);
  localparam int PeriodClocks = PWMPeriod_ns / ClockPeriod_ns;
  localparam int MW = Size - 1;
  localparam int HW = $clog2(ZeroHoldPeriods + 1);
  localparam logic [MW-1:0] StepM = MW'(Step);

  pwm_state_e state_q, state_d;
  logic [Size-1:0] data_q, data_d, target_q, target_d, cmd_n, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [MW-1:0] dmag, tmag, diff, delta, step_mag;
  logic tick, accept, same_sign, step_sign, hold_done;

  pwm_period_tick #(.N(PeriodClocks)) u_tick (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .Tick   (tick)
  );

  assign dmag      = data_q[MW-1:0];
  assign tmag      = target_q[MW-1:0];
  assign cmd_n     = {norm_sign(CmdData[Size-1], |CmdData[MW-1:0]), CmdData[MW-1:0]};
  assign CmdReady  = Reset_n && !Stop && state_q != ZERO_HOLD;
  assign accept    = CmdValid && CmdReady;
  assign target_d  = Stop ? '0 : accept ? cmd_n : target_q;
  // A step always uses the registered target, so a retarget on a Tick edge takes effect one period later.
  assign same_sign = data_q[Size-1] == target_q[Size-1] || dmag == '0;
  assign diff      = !same_sign ? dmag : dmag > tmag ? dmag - tmag : tmag - dmag;
  assign delta     = diff < StepM ? diff : StepM;
  assign step_mag  = (same_sign && dmag < tmag) ? dmag + delta : dmag - delta;
  assign step_sign = same_sign ? target_q[Size-1] : data_q[Size-1];
  assign step_d    = {norm_sign(step_sign, |step_mag), step_mag};
  assign hold_done = hold_q == HW'(ZeroHoldPeriods - 1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    hold_d  = hold_q;
    if (Stop) begin
      state_d = IDLE;
      data_d  = '0;
      hold_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = (accept && cmd_n != data_q) ? RAMP : IDLE;
    end else if (state_q == RAMP) begin
      data_d  = tick ? step_d : data_q;
      state_d = data_d == target_d ? IDLE :
                (tick && !same_sign && step_mag == '0) ? ZERO_HOLD : RAMP;
    end else if (tick) begin
      hold_d  = hold_done ? '0 : hold_q + 1'b1;
      state_d = !hold_done ? ZERO_HOLD : target_q == '0 ? IDLE : RAMP;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      target_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end

  assign Data     = data_q;
  assign Tick     = tick;
  assign Busy     = state_q != IDLE;
  assign AtTarget = data_q == target_q;
endmodule
